// File: rtl/serial_mac_nibble.sv
// Nibble-serial multiply/accumulate tile: operands stream in INW bits at a time,
// a shift-add engine forms the product, and the result streams out OUTW bits at a time.
module serial_mac_nibble #(
    parameter int OPW  = 8,
    parameter int INW  = 4,
    parameter int OUTW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [INW-1:0]  in_data,
    input  logic            signed_mode,
    input  logic            acc_mode,
    output logic [OUTW-1:0] out_data,
    output logic            out_valid,
    output logic            busy
);

    localparam int RESW = 2 * OPW;
    localparam int NIN  = RESW / INW;
    localparam int NOUT = RESW / OUTW;
    localparam int CW   = $clog2(RESW + 1);

    localparam logic [CW-1:0] IN_LAST   = CW'(NIN - 1);
    localparam logic [CW-1:0] MULT_LAST = CW'(OPW - 1);
    localparam logic [CW-1:0] OUT_LAST  = CW'(NOUT - 1);

    typedef enum logic [1:0] {LOAD, MULT, FIN, OUT} state_t;

    state_t state, state_next;

    logic [CW-1:0]   cnt;
    logic [RESW-1:0] load_sr;
    logic [RESW-1:0] load_word;
    logic [OPW-1:0]  op_a, op_b;
    logic [RESW-1:0] mcand;
    logic [OPW:0]    mplier;
    logic [RESW-1:0] partial, partial_next;
    logic [RESW-1:0] acc, acc_next;
    logic [RESW-1:0] out_sr, out_shift;
    logic            smode, amode, neg;
    logic            accept, last_in, mult_done, out_done;

    // Widened by one bit so the most negative operand keeps its true magnitude.
    function automatic logic [OPW:0] magnitude(input logic [OPW-1:0] v, input logic is_signed);
        logic signed [OPW:0] ext;
        ext = is_signed ? {v[OPW-1], v} : {1'b0, v};
        return (ext < 0) ? $unsigned(-ext) : $unsigned(ext);
    endfunction

    function automatic logic [RESW-1:0] apply_sign(input logic [RESW-1:0] mag, input logic negate);
        logic signed [RESW-1:0] s;
        s = signed'(mag);
        return negate ? $unsigned(-s) : mag;
    endfunction

    assign load_word    = {load_sr[RESW-INW-1:0], in_data};
    assign op_a         = load_word[RESW-1:OPW];
    assign op_b         = load_word[OPW-1:0];
    assign accept       = in_valid && (state == LOAD);
    assign last_in      = accept && (cnt == IN_LAST);
    assign mult_done    = (state == MULT) && (cnt == MULT_LAST);
    assign out_done     = (state == OUT) && (cnt == OUT_LAST);
    assign partial_next = mplier[0] ? partial + mcand : partial;
    assign acc_next     = amode ? acc + apply_sign(partial, neg) : apply_sign(partial, neg);
    assign out_shift    = out_sr << OUTW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            LOAD: begin
                busy = 1'b0;
                if (last_in) state_next = MULT;
            end
            MULT:    if (mult_done) state_next = FIN;
            FIN:     state_next = OUT;
            OUT:     if (out_done) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Control, accumulator and output port: cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            smode     <= 1'b0;
            amode     <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (cnt == '0) begin
                            smode <= signed_mode;
                            amode <= acc_mode;
                        end
                        cnt <= last_in ? '0 : cnt + CW'(1);
                    end
                end
                MULT: cnt <= mult_done ? '0 : cnt + CW'(1);
                FIN: begin
                    acc       <= acc_next;
                    out_data  <= acc_next[RESW-1 -: OUTW];
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end
                OUT: begin
                    if (out_done) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        cnt       <= '0;
                    end else begin
                        out_data <= out_shift[RESW-1 -: OUTW];
                        cnt      <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Datapath registers: every value is rewritten before it is consumed.
    always_ff @(posedge clk) begin
        if (accept) load_sr <= load_word;
        if (last_in) begin
            mcand   <= RESW'(magnitude(op_a, smode));
            mplier  <= magnitude(op_b, smode);
            partial <= '0;
            neg     <= smode & (op_a[OPW-1] ^ op_b[OPW-1]);
        end else if (state == MULT) begin
            partial <= partial_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
        end
        if (state == FIN)      out_sr <= acc_next;
        else if (state == OUT) out_sr <= out_shift;
    end

endmodule
